lane_descrambler: RTL and testbench
===================================

# lane_descrambler

Per-lane Gen1/Gen2 receive descrambler in the PCIe 5.0 MAC RX path. It sits directly upstream of the unstriping stage. It takes the per-lane PIPE receive symbols and removes the scrambling using one 16-bit LFSR per lane, handling COM and SKP ordered-set symbols. It presents descrambled per-lane symbols on the bus layout the unstriping stage consumes.

## Interface
- Parameters: none. Lane count (16) and per-lane width (32 bits, 4 symbols) are fixed.
- `clk` input 1: the single clock; all state is updated on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `PIPEWIDTH` input 6: PIPE width per lane. Only 32 is supported.
- `LANESNUMBER` input 5: number of active lanes. Supported values are 1, 2, 4, 8 and 16.
- `rxValid` input 1: qualifies `rxData`/`rxDataK` for the current cycle.
- `descrambleBypass` input 1: when 1, data symbols pass through unmodified; the LFSRs still advance.
- `rxData` input 512: lane L occupies [32L+31:32L]; symbol b of lane L is at [32L+8b+7:32L+8b]; b=0 is first in time.
- `rxDataK` input 64: K flag for each symbol, at bit 4L+b.
- `strippedData` output 512: descrambled symbols, same layout as `rxData`. Feeds the unstriping stage.
- `strippedDataK` output 64: registered copy of `rxDataK`, same layout.
- `strippedValid` output 1: registered copy of `rxValid`, gated by configuration.

## Operation
- **Lane activity.** Lane L is active when PIPEWIDTH==32 and L < LANESNUMBER and LANESNUMBER is a supported value.
  - Inactive lanes: outputs are 0 and the lane's LFSR is held at 16'hFFFF.
  - Unsupported configuration: all lanes are inactive and `strippedValid`=0.
- **LFSR.** Polynomial x^16+x^5+x^4+x^3+1, seed 16'hFFFF, Galois form.
  - One shift: mask bit = S[15]; S' = {S[14:0],1'b0} ^ (S[15] ? 16'h0039 : 16'h0000).
  - Byte mask: 8 consecutive shifts. Shift i supplies mask bit i (i=0 gives the LSB).
- **Per-symbol rules.** Symbols are processed in order b=0..3 within a cycle, and the LFSR state chains through them.
  - COM (K=1, 8'hBC): passed through unmodified. The LFSR is loaded with 16'hFFFF for the next symbol.
  - SKP (K=1, 8'h1C): passed through unmodified. The LFSR does not advance.
  - Any other K symbol: passed through unmodified. The LFSR advances 8 shifts.
  - Data symbol (K=0): output = input XOR byte mask, or input unmodified when `descrambleBypass`=1. The LFSR advances 8 shifts.
- **rxValid=0.** No LFSR advances. `strippedData`/`strippedDataK` are registered as 0 and `strippedValid`=0.
- **Config changes.** When LANESNUMBER or PIPEWIDTH changes, a lane that becomes inactive reloads 16'hFFFF that cycle. A lane that stays active keeps its state.
- **Independence.** Lanes are fully independent. A COM on one lane does not affect any other lane.

## Timing
- **Reset.** While `reset`=0 (asynchronous assertion), `strippedData`=0, `strippedDataK`=0, `strippedValid`=0, and all 16 LFSRs = 16'hFFFF. Deassertion takes effect at the next rising edge.
- **Latency.** Exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- **LFSR update.** The next-state LFSR for edge N is the state after symbol 3 of the cycle sampled at N. A COM at b=3 leaves 16'hFFFF for b=0 of the next valid cycle.
- **Reset mid-stream.** All lanes restart from 16'hFFFF. The first data after reset, with no preceding COM, is descrambled with mask FF.
- **Outputs.** All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset values.** Assert `reset`=0 mid-traffic -> all outputs 0 immediately. After release, with PIPEWIDTH=32, LANESNUMBER=16, rxValid=1, and lane 0 = {00,00,00,BC} (b0=COM), the next cycle carries lane 0 = {00,00,00,00} -> output lane 0 bytes b0..b3 = FF,17,C0,14.
- **COM within a cycle.** Lane 3 symbols b0..b3 = BC(K),00,00,BC(K) -> output BC,FF,17,BC. The following cycle's data 00,00 -> FF,17.
- **SKP handling.** COM, then data 00, then SKP, SKP, then data 00 -> output BC,FF,1C,1C,17. SKP does not advance the LFSR.
- **rxValid gaps.** After COM plus 00 (output FF), hold rxValid=0 for 3 cycles -> outputs 0 and `strippedValid`=0. The next valid 00 -> 17.
- **Lane masking.** LANESNUMBER=4 with all-lane COM+00 traffic -> lanes 0..3 output FF, lanes 4..15 output 0. Switch to 16 -> lanes 4..15 start from FFFF (first data 00 -> FF). PIPEWIDTH=16 -> all outputs 0 and `strippedValid`=0.
- **Bypass.** With `descrambleBypass`=1, COM then 00,00 -> output 00,00. Then clear bypass and send the next 00 -> C0, confirming the LFSR kept advancing during bypass.

Source files
------------

// File: rtl/lane_descrambler.sv
// Per-lane Gen1/Gen2 receive descrambler: 16 lanes x 4 symbols, one Galois LFSR per lane,
// COM reseeds and SKP holds the LFSR. All outputs registered, one cycle of latency.
module lane_descrambler (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   PIPEWIDTH,
  input  logic [4:0]   LANESNUMBER,
  input  logic         rxValid,
  input  logic         descrambleBypass,
  input  logic [511:0] rxData,
  input  logic [63:0]  rxDataK,
  output logic [511:0] strippedData,
  output logic [63:0]  strippedDataK,
  output logic         strippedValid
);

  localparam logic [7:0]  SymCom   = 8'hBC;
  localparam logic [7:0]  SymSkp   = 8'h1C;
  localparam logic [15:0] LfsrSeed = 16'hFFFF;
  localparam logic [15:0] LfsrTaps = 16'h0039;

  // Eight Galois shifts; returns {byte mask, next state}, mask bit i from shift i.
  function automatic logic [23:0] lfsr_byte(input logic [15:0] s_in);
    logic [15:0] s;
    logic [7:0]  m;
    s = s_in;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i] = s[15];
      s    = {s[14:0], 1'b0} ^ (s[15] ? LfsrTaps : 16'h0000);
    end
    return {m, s};
  endfunction

  logic [15:0][15:0] lfsr_q, lfsr_d;
  logic [511:0]      data_q, data_d;
  logic [63:0]       k_q, k_d;
  logic              valid_q, valid_d;
  logic              cfg_ok;
  logic [15:0]       lane_act;
  logic [15:0]       st;
  logic [7:0]        sym;
  logic              is_k;
  logic [23:0]       stepped;

  assign cfg_ok = (PIPEWIDTH == 6'd32) &&
                  (LANESNUMBER inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16});

  always_comb begin
    lane_act = '0;
    for (int l = 0; l < 16; l++) begin
      lane_act[l] = cfg_ok && (5'(l) < LANESNUMBER);
    end
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    data_d  = '0;
    k_d     = '0;
    valid_d = rxValid && cfg_ok;
    st      = LfsrSeed;
    sym     = '0;
    is_k    = 1'b0;
    stepped = '0;
    for (int l = 0; l < 16; l++) begin
      if (!lane_act[l]) begin
        lfsr_d[l] = LfsrSeed;
      end else if (rxValid) begin
        // State chains through b=0..3 so a COM mid-cycle reseeds the later symbols.
        st = lfsr_q[l];
        for (int b = 0; b < 4; b++) begin
          sym     = rxData[32*l+8*b +: 8];
          is_k    = rxDataK[4*l+b];
          stepped = lfsr_byte(st);
          data_d[32*l+8*b +: 8] = sym;
          if (!is_k) begin
            if (!descrambleBypass) data_d[32*l+8*b +: 8] = sym ^ stepped[23:16];
            st = stepped[15:0];
          end else if (sym == SymCom) begin
            st = LfsrSeed;
          end else if (sym != SymSkp) begin
            st = stepped[15:0];
          end
        end
        lfsr_d[l]       = st;
        k_d[4*l +: 4]   = rxDataK[4*l +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q  <= {16{LfsrSeed}};
      data_q  <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
    end
  end

  assign strippedData  = data_q;
  assign strippedDataK = k_q;
  assign strippedValid = valid_q;

endmodule

// File: tb/tb_lane_descrambler.sv
// Directed bench for lane_descrambler; expected words are hand-computed LFSR masks
// (first bytes from seed FFFF: FF, 17, C0, 14). Lane words read b3..b0 left to right.
module tb_lane_descrambler;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   PIPEWIDTH;
  logic [4:0]   LANESNUMBER;
  logic         rxValid;
  logic         descrambleBypass;
  logic [511:0] rxData;
  logic [63:0]  rxDataK;
  logic [511:0] strippedData;
  logic [63:0]  strippedDataK;
  logic         strippedValid;

  int n_checks = 0;
  int n_pass   = 0;

  lane_descrambler dut (
    .clk              (clk),
    .reset            (reset),
    .PIPEWIDTH        (PIPEWIDTH),
    .LANESNUMBER      (LANESNUMBER),
    .rxValid          (rxValid),
    .descrambleBypass (descrambleBypass),
    .rxData           (rxData),
    .rxDataK          (rxDataK),
    .strippedData     (strippedData),
    .strippedDataK    (strippedDataK),
    .strippedValid    (strippedValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] d, input logic [3:0] k);
    rxData[32*l +: 32] = d;
    rxDataK[4*l +: 4]  = k;
  endtask

  task automatic set_all(input logic [31:0] d, input logic [3:0] k);
    for (int l = 0; l < 16; l++) set_lane(l, d, k);
  endtask

  function automatic logic [31:0] lane_out(input int l);
    return strippedData[32*l +: 32];
  endfunction

  function automatic logic [3:0] lane_k(input int l);
    return strippedDataK[4*l +: 4];
  endfunction

  initial begin
    reset            = 1'b0;
    PIPEWIDTH        = 6'd32;
    LANESNUMBER      = 5'd16;
    rxValid          = 1'b0;
    descrambleBypass = 1'b0;
    rxData           = '0;
    rxDataK          = '0;
    #2;
    check("por_data", strippedData, '0);
    check("por_k", {448'd0, strippedDataK}, '0);
    check("por_valid", {511'd0, strippedValid}, '0);
    tick();
    reset = 1'b1;

    // Some traffic, then asynchronous reset mid-cycle.
    rxValid = 1'b1;
    set_all(32'h1234_5678, 4'h0);
    tick();
    tick();
    check("pre_rst_valid", {511'd0, strippedValid}, 512'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_data", strippedData, '0);
    check("rst_async_k", {448'd0, strippedDataK}, '0);
    check("rst_async_valid", {511'd0, strippedValid}, '0);
    tick();
    reset = 1'b1;

    // Lane 0: COM then SKPs; lane 5: data straight after reset uses the seed.
    set_all(32'h0, 4'h0);
    set_lane(0, 32'h1C1C_1CBC, 4'hF);
    tick();
    check("rst_l0_com", {480'd0, lane_out(0)}, {480'd0, 32'h1C1C_1CBC});
    check("rst_l5_first", {480'd0, lane_out(5)}, {480'd0, 32'h14C0_17FF});
    check("rst_valid", {511'd0, strippedValid}, 512'd1);
    set_lane(0, 32'h0, 4'h0);
    tick();
    check("rst_l0_data", {480'd0, lane_out(0)}, {480'd0, 32'h14C0_17FF});

    // COM inside a cycle (lane 3), SKP hold (lane 2), other K advances (lane 7).
    set_all(32'h0, 4'h0);
    set_lane(3, 32'hBC00_00BC, 4'h9);
    set_lane(2, 32'h1C1C_00BC, 4'hD);
    set_lane(7, 32'h0000_F7BC, 4'h3);
    tick();
    check("com_mid_l3", {480'd0, lane_out(3)}, {480'd0, 32'hBC17_FFBC});
    check("com_mid_l3_k", {508'd0, lane_k(3)}, {508'd0, 4'h9});
    check("skp_l2", {480'd0, lane_out(2)}, {480'd0, 32'h1C1C_FFBC});
    check("kadv_l7", {480'd0, lane_out(7)}, {480'd0, 32'hC017_F7BC});
    set_all(32'h0, 4'h0);
    set_lane(2, 32'h1C1C_1C00, 4'hE);
    tick();
    check("com_next_l3", {480'd0, lane_out(3)}, {480'd0, 32'h14C0_17FF});
    check("com_next_l3_k", {508'd0, lane_k(3)}, '0);
    check("skp_next_l2", {480'd0, lane_out(2)}, {480'd0, 32'h1C1C_1C17});

    // rxValid gaps on lane 1.
    set_lane(1, 32'h1C1C_00BC, 4'hD);
    tick();
    check("gap_pre_l1", {480'd0, lane_out(1)}, {480'd0, 32'h1C1C_FFBC});
    rxValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_data", strippedData, '0);
      check("gap_valid", {511'd0, strippedValid}, '0);
    end
    rxValid = 1'b1;
    set_lane(1, 32'h1C1C_1C00, 4'hE);
    tick();
    check("gap_post_l1", {480'd0, lane_out(1)}, {480'd0, 32'h1C1C_1C17});

    // Lane masking.
    LANESNUMBER = 5'd4;
    set_all(32'h1C1C_00BC, 4'hD);
    tick();
    check("mask4_l0", {480'd0, lane_out(0)}, {480'd0, 32'h1C1C_FFBC});
    check("mask4_l3", {480'd0, lane_out(3)}, {480'd0, 32'h1C1C_FFBC});
    check("mask4_hi", {128'd0, strippedData[511:128]}, '0);
    check("mask4_hik", {464'd0, strippedDataK[63:16]}, '0);
    LANESNUMBER = 5'd16;
    set_all(32'h1C1C_1C00, 4'hE);
    tick();
    check("mask16_l3", {480'd0, lane_out(3)}, {480'd0, 32'h1C1C_1C17});
    check("mask16_l4", {480'd0, lane_out(4)}, {480'd0, 32'h1C1C_1CFF});
    check("mask16_l15", {480'd0, lane_out(15)}, {480'd0, 32'h1C1C_1CFF});
    PIPEWIDTH = 6'd16;
    tick();
    check("pw16_data", strippedData, '0);
    check("pw16_valid", {511'd0, strippedValid}, '0);
    PIPEWIDTH   = 6'd32;
    LANESNUMBER = 5'd3;
    tick();
    check("ln3_valid", {511'd0, strippedValid}, '0);
    check("ln3_data", strippedData, '0);
    LANESNUMBER = 5'd16;
    set_all(32'h0, 4'h0);
    tick();
    check("recfg_l0", {480'd0, lane_out(0)}, {480'd0, 32'h14C0_17FF});
    check("recfg_valid", {511'd0, strippedValid}, 512'd1);

    // Bypass on lane 6: LFSR keeps advancing underneath.
    descrambleBypass = 1'b1;
    set_all(32'h0, 4'h0);
    set_lane(6, 32'h1C00_00BC, 4'h9);
    tick();
    check("byp_l6", {480'd0, lane_out(6)}, {480'd0, 32'h1C00_00BC});
    descrambleBypass = 1'b0;
    set_lane(6, 32'h1C1C_1C00, 4'hE);
    tick();
    check("byp_after_l6", {480'd0, lane_out(6)}, {480'd0, 32'h1C1C_1CC0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
